// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8N1 UART receiver with show-ahead receive FIFO (even parity when UART_RX_PARITY_EN is defined)
module uart_rx_fifo #(
    parameter int FIFO_AW = 3,
    parameter int DIV_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rxd,
    input  logic [DIV_W-1:0] baud_div,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             frame_err,
    output logic             overrun,
    output logic             busy
);

    localparam int               DEPTH   = 1 << FIFO_AW;
    localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(4);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    logic [1:0]         sync_q;
    logic               rxs;
    state_t             state;
    logic [DIV_W-1:0]   div;
    logic [DIV_W-1:0]   div_in;
    logic [DIV_W-1:0]   cnt;
    logic [2:0]         bit_idx;
    logic [7:0]         shift;
    logic               par_err;
    logic [FIFO_AW:0]   wr_ptr;
    logic [FIFO_AW:0]   rd_ptr;
    logic [7:0]         mem [DEPTH];
    logic               tick;
    logic               stop_sample;
    logic               good_stop;
    logic               full;
    logic               empty;
    logic               pop;
    logic               push;

    assign rxs         = sync_q[1];
    assign div_in      = (baud_div < DIV_MIN) ? DIV_MIN : baud_div;
    assign tick        = (cnt == '0);
    assign stop_sample = (state == S_STOP) && tick;
    assign good_stop   = stop_sample && rxs && !par_err;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                      (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    assign pop      = rx_ready && !empty;
    // A full FIFO still takes the byte if the head leaves in the same cycle.
    assign push     = good_stop && (!full || pop);
    assign rx_valid = !empty;
    assign rx_data  = empty ? 8'h00 : mem[rd_ptr[FIFO_AW-1:0]];
    assign busy     = (state != S_IDLE);

`ifndef UART_RX_PARITY_EN
    assign par_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rxd};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            div       <= DIV_MIN;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err   <= 1'b0;
`endif
        end else begin
            frame_err <= stop_sample && !good_stop;
            overrun   <= good_stop && full && !pop;
            case (state)
                S_IDLE: begin
                    div <= div_in;
                    if (!rxs) begin
                        state <= S_START;
                        cnt   <= (div_in >> 1) - DIV_W'(1);
                    end
                end
                S_START: begin
                    if (tick) begin
                        if (!rxs) begin
                            state   <= S_DATA;
                            cnt     <= div - DIV_W'(1);
                            bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
                            par_err <= 1'b0;
`endif
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt - DIV_W'(1);
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        shift   <= {rxs, shift[7:1]};
                        cnt     <= div - DIV_W'(1);
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= S_PARITY;
`else
                            state <= S_STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt - DIV_W'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (tick) begin
                        par_err <= ^{rxs, shift};
                        cnt     <= div - DIV_W'(1);
                        state   <= S_STOP;
                    end else begin
                        cnt <= cnt - DIV_W'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (tick) begin
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt - DIV_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (FIFO_AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (FIFO_AW+1)'(1);
            end
        end
    end

    // Storage is deliberately left unreset; the empty gate on rx_data hides it.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr[FIFO_AW-1:0]] <= shift;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rxd = 1'b1;
    logic [15:0] baud_div = 16'd16;
    logic        rx_ready = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        frame_err;
    logic        overrun;
    logic        busy;

    uart_rx_fifo dut (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .baud_div  (baud_div),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {int at; bit bad; logic [7:0] d;} ev_t;
    typedef struct {int lo; int hi;} win_t;

    int         cyc = 0;
    int         tests = 0;
    int         fails = 0;
    bit         chk_en = 0;
    ev_t        evq[$];
    win_t       winq[$];
    logic [7:0] mq[$];
    logic [7:0] rd_q[$];
    bit         exp_fe = 0;
    bit         exp_ov = 0;
    int         rise_cyc = 0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    bit         prev_valid = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic int eff_div(input logic [15:0] bd);
        return (bd < 16'd4) ? 4 : int'(bd);
    endfunction

    function automatic int lat_of(input int div);
`ifdef UART_RX_PARITY_EN
        return 3 + div/2 + 10*div;
`else
        return 3 + div/2 + 9*div;
`endif
    endfunction

    function automatic int frame_len(input int div);
`ifdef UART_RX_PARITY_EN
        return 11*div;
`else
        return 10*div;
`endif
    endfunction

    // Model: a byte appears (or a flag fires) a fixed latency after its falling edge.
    always @(posedge clk) begin : model
        int         c;
        bit         pop;
        bit         push;
        logic [7:0] pd;
        ev_t        ev;
        c = cyc + 1;
        cyc <= c;
        exp_fe = 0;
        exp_ov = 0;
        if (rst) begin
            mq.delete();
            evq.delete();
            winq.delete();
        end else begin
            pop  = rx_ready && (mq.size() > 0);
            push = 0;
            pd   = 8'h00;
            if (evq.size() > 0 && evq[0].at == c) begin
                ev = evq.pop_front();
                if (ev.bad) exp_fe = 1;
                else if (mq.size() == 8 && !pop) exp_ov = 1;
                else begin
                    push = 1;
                    pd   = ev.d;
                end
            end
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(pd);
        end
    end

    always @(negedge clk) begin : compare
        bit exp_busy;
        if (chk_en) begin
            exp_busy = 0;
            foreach (winq[i]) if (cyc >= winq[i].lo && cyc < winq[i].hi) exp_busy = 1;
            chk("rx_valid", {31'd0, rx_valid}, {31'd0, mq.size() > 0});
            chk("rx_data", {24'd0, rx_data}, {24'd0, (mq.size() > 0) ? mq[0] : 8'h00});
            chk("frame_err", {31'd0, frame_err}, {31'd0, exp_fe});
            chk("overrun", {31'd0, overrun}, {31'd0, exp_ov});
            chk("busy", {31'd0, busy}, {31'd0, exp_busy});
        end
    end

    always @(negedge clk) begin : monitor
        if (rx_valid === 1'b1 && !prev_valid) rise_cyc = cyc;
        prev_valid = (rx_valid === 1'b1);
        if (frame_err === 1'b1) fe_cnt++;
        if (overrun === 1'b1) ov_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called #1 after an edge; returns #1 after the edge ending the stop bit.
    task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit par_ok,
                              input int abort_at, output int t0);
        int          div;
        int          nb;
        int          lat;
        logic [10:0] fb;
        bit          aborted;
        div = eff_div(baud_div);
        lat = lat_of(div);
`ifdef UART_RX_PARITY_EN
        fb = {stop_ok, (^d) ^ !par_ok, d, 1'b0};
        nb = 11;
`else
        fb = {1'b0, stop_ok, d, 1'b0};
        nb = 10;
`endif
        t0 = cyc;
        winq.push_back('{t0 + 3, t0 + lat});
        evq.push_back('{t0 + lat, !(stop_ok && par_ok), d});
        aborted = 0;
        for (int i = 0; i < nb && !aborted; i++) begin
            rxd = fb[i];
            if (i == abort_at) begin
                tick(2);
                aborted = 1;
            end else begin
                tick(div);
            end
        end
        if (!aborted) rxd = 1'b1;
    endtask

    task automatic drain();
        rd_q.delete();
        rx_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rx_valid !== 1'b1) break;
            rd_q.push_back(rx_data);
        end
        rx_ready = 1'b0;
        tick(1);
    endtask

    initial begin : stim
        int t0;
        int tstart;
        int push9;
        int div;
        tick(1);
        chk_en = 1;
        chk("reset rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("reset rx_data", {24'd0, rx_data}, 32'h00);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset frame_err", {31'd0, frame_err}, 32'd0);
        chk("reset overrun", {31'd0, overrun}, 32'd0);
        tick(2);
        rst = 1'b0;
        tick(3);

        send_frame(8'h55, 1, 1, -1, t0);
        tick(2);
`ifdef UART_RX_PARITY_EN
        chk("latency_55", rise_cyc - t0, 32'd171);
`else
        chk("latency_55", rise_cyc - t0, 32'd155);
`endif
        chk("data_55", {24'd0, rx_data}, 32'h55);
        chk("flags_55", fe_cnt + ov_cnt, 32'd0);
        drain();
        chk("drain_55_count", rd_q.size(), 32'd1);

        send_frame(8'hA5, 1, 1, -1, t0);
        send_frame(8'h3C, 1, 1, -1, t0);
        send_frame(8'hFF, 1, 1, -1, t0);
        tick(2);
        drain();
        chk("b2b_count", rd_q.size(), 32'd3);
        if (rd_q.size() == 3) begin
            chk("b2b_0", {24'd0, rd_q[0]}, 32'hA5);
            chk("b2b_1", {24'd0, rd_q[1]}, 32'h3C);
            chk("b2b_2", {24'd0, rd_q[2]}, 32'hFF);
        end

        ov_cnt = 0;
        for (int i = 0; i < 9; i++) send_frame(8'(i), 1, 1, -1, t0);
        tick(2);
        chk("overrun_count", ov_cnt, 32'd1);
        drain();
        chk("full_count", rd_q.size(), 32'd8);
        foreach (rd_q[i]) chk("full_data", {24'd0, rd_q[i]}, i);

        ov_cnt = 0;
        div    = eff_div(baud_div);
        tstart = cyc;
        push9  = tstart + 8 * frame_len(div) + lat_of(div);
        fork
            begin
                int tt;
                for (int i = 0; i < 9; i++) send_frame(8'(i), 1, 1, -1, tt);
            end
            begin
                while (cyc < push9 - 1) tick(1);
                rx_ready = 1'b1;
                tick(1);
                rx_ready = 1'b0;
            end
        join
        tick(2);
        chk("pop_push_overrun", ov_cnt, 32'd0);
        drain();
        chk("pop_push_count", rd_q.size(), 32'd8);
        foreach (rd_q[i]) chk("pop_push_data", {24'd0, rd_q[i]}, i + 1);

        fe_cnt = 0;
        t0 = cyc;
        winq.push_back('{t0 + 3, t0 + 3 + 8});
        rxd = 1'b0;
        tick(5);
        rxd = 1'b1;
        tick(30);
        chk("glitch_fe", fe_cnt, 32'd0);
        chk("glitch_valid", {31'd0, rx_valid}, 32'd0);
        chk("glitch_busy", {31'd0, busy}, 32'd0);

        // Stop bit held low: the tail of it looks like a start that fails mid-bit.
        t0 = cyc;
        winq.push_back('{t0 + lat_of(16) + 1, t0 + lat_of(16) + 1 + 8});
        send_frame(8'h80, 0, 1, -1, t0);
        tick(20);
        chk("stop_low_fe", fe_cnt, 32'd1);
        chk("stop_low_valid", {31'd0, rx_valid}, 32'd0);

        baud_div = 16'd2;
        tick(2);
        send_frame(8'hC3, 1, 1, -1, t0);
        tick(3);
        chk("div4_data", {24'd0, rx_data}, 32'hC3);
        fe_cnt = 0;
        send_frame(8'hE7, 1, 1, 4, t0);
        rxd = 1'b1;
        rst = 1'b1;
        tick(1);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_valid", {31'd0, rx_valid}, 32'd0);
        chk("abort_data", {24'd0, rx_data}, 32'h00);
        tick(2);
        rst = 1'b0;
        tick(3);
        send_frame(8'h5A, 1, 1, -1, t0);
        tick(3);
        drain();
        chk("after_rst_count", rd_q.size(), 32'd1);
        if (rd_q.size() == 1) chk("after_rst_data", {24'd0, rd_q[0]}, 32'h5A);
        chk("abort_fe", fe_cnt, 32'd0);

`ifdef UART_RX_PARITY_EN
        baud_div = 16'd16;
        tick(2);
        fe_cnt = 0;
        send_frame(8'h07, 1, 1, -1, t0);
        tick(3);
        drain();
        chk("par_ok_count", rd_q.size(), 32'd1);
        if (rd_q.size() == 1) chk("par_ok_data", {24'd0, rd_q[0]}, 32'h07);
        send_frame(8'h07, 1, 0, -1, t0);
        tick(3);
        chk("par_bad_fe", fe_cnt, 32'd1);
        chk("par_bad_valid", {31'd0, rx_valid}, 32'd0);
`endif

        tick(5);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
